step_input_cond: RTL and testbench
==================================

STEP_INPUT_COND -- requirements
Module: step_input_cond

Interface
REQ-001 Parameter DB_CYCLES, default 8, consecutive stable cycles required to accept a debounced level change; legal range 2..255.
REQ-002 Parameter HOLD_CYCLES, default 64, cycles a step button is held after its first pulse before auto-repeat starts; legal range 2..65535.
REQ-003 Parameter REPEAT_CYCLES, default 16, period in cycles between auto-repeat pulses; legal range 2..65535.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously with clk.
REQ-006 btn_up  input  1  raw asynchronous up-step button, active high.
REQ-007 btn_down  input  1  raw asynchronous down-step button, active high.
REQ-008 btn_load  input  1  raw asynchronous load button, active high.
REQ-009 load_val  input  4  raw load value, quasi-static.
REQ-010 step_en  output  1  one-cycle pulse per step request; drives the counter enable.
REQ-011 step_up  output  1  level; 1 = count up, 0 = count down; holds direction of the last step pulse.
REQ-012 load  output  1  one-cycle pulse requesting a counter load.
REQ-013 load_value  output  4  value to load; valid and stable whenever load is high.

Function
REQ-014 btn_up, btn_down, btn_load and each load_val bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each button SHALL have an independent debouncer: 8-bit counter cleared whenever the synchronized level equals the debounced level, incremented otherwise; debounced level flips, and counter clears, on the edge where a mismatch is seen with counter = DB_CYCLES-1.
REQ-016 A glitch shorter than DB_CYCLES cycles SHALL not change the debounced level.
REQ-017 Latency: with a clean raw rise first sampled at edge 1, the resulting pulse SHALL be high exactly in the cycle after edge DB_CYCLES+3.
REQ-018 Step FSM states: IDLE, HOLD, REPEAT; 16-bit timer; all outputs registered.
REQ-019 IDLE: on debounced rise of exactly one of up/down with the other debounced low -> pulse step_en, set step_up (1 for up, 0 for down), clear timer, go HOLD.
REQ-020 HOLD: timer increments each cycle; on timer reaching HOLD_CYCLES-1 with the same button still held -> pulse step_en, clear timer, go REPEAT.
REQ-021 REPEAT: timer increments; on reaching REPEAT_CYCLES-1 -> pulse step_en, clear timer, stay REPEAT.
REQ-022 In HOLD or REPEAT, debounced release of the active button, or the other step button becoming debounced high, SHALL return to IDLE with no pulse that cycle.
REQ-023 Both step buttons debounced high simultaneously SHALL produce no step pulses; FSM stays IDLE until a fresh single-button rise.
REQ-024 Debounced rise of btn_load SHALL pulse load for one cycle with load_value = synchronized load_val sampled on the same edge; holding btn_load SHALL NOT repeat.
REQ-025 A cycle with load high SHALL force step_en low and return the step FSM to IDLE; step_up unchanged.
REQ-026 step_en and load SHALL never be high in the same cycle; step_en SHALL never be high on consecutive cycles.

Reset
REQ-027 While rst_n low: step_en=0, step_up=0, load=0, load_value=0, FSM=IDLE, all synchronizer, debounced and counter state 0.
REQ-028 Reset mid-hold or mid-repeat SHALL abort with no pulse; after release a still-held button SHALL produce a pulse via a fresh debounce (REQ-017 latency from first post-reset edge).

Verification
REQ-029 DB_CYCLES=8: btn_up high and held 10 cycles -> single step_en pulse at cycle 11 after first sample, step_up=1; no further pulse.
REQ-030 btn_down glitch high for 5 cycles -> no step_en, step_up unchanged.
REQ-031 HOLD_CYCLES=64, REPEAT_CYCLES=16, btn_up held 200 cycles after debounce -> pulses at t0, t0+64, t0+80, t0+96, ...; none after release.
REQ-032 load_val=4'hA, btn_load pressed while btn_up in REPEAT -> load=1 with load_value=4'hA, step_en=0 that cycle, no further step pulses until btn_up re-pressed.
REQ-033 btn_up and btn_down pressed together for 100 cycles -> zero step_en pulses.
REQ-034 rst_n pulsed low during REPEAT -> all outputs 0 immediately; next step_en only after DB_CYCLES+3 cycles post-release.

Source files
------------

// File: rtl/step_input_cond.sv
// Button front end for a step counter: synchronizes and debounces up/down/load,
// then turns up/down presses into step pulses with hold-off and auto-repeat.
//
// state     | meaning
// ST_IDLE   | waiting for a fresh single-button debounced rise
// ST_HOLD   | first step issued, timing the hold-off before auto-repeat
// ST_REPEAT | auto-repeat, one step every REPEAT_CYCLES
module step_input_cond #(
   parameter int DB_CYCLES     = 8,
   parameter int HOLD_CYCLES   = 64,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_load,
   input  logic [3:0] load_val,
   output logic       step_en,
   output logic       step_up,
   output logic       load,
   output logic [3:0] load_value
);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

   localparam logic [7:0]  DB_TC   = 8'(DB_CYCLES - 1);
   localparam logic [15:0] HOLD_TC = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] REP_TC  = 16'(REPEAT_CYCLES - 1);

   // bit 0 = up, bit 1 = down, bit 2 = load
   logic [2:0]      btn_s1_q, btn_s2_q;
   logic [3:0]      lv_s1_q, lv_s2_q;
   logic [2:0]      deb_q, deb_d, deb_prev_q, rise;
   logic [2:0][7:0] db_cnt_q, db_cnt_d;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        step_en_q, step_en_d;
   logic        step_up_q, step_up_d;
   logic        load_q, load_d;
   logic [3:0]  load_value_q, load_value_d;
   logic        active_held, other_held;

   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (btn_s2_q[i] == deb_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_TC) begin
            deb_d[i]    = ~deb_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 8'd1;
         end
      end
   end

   assign rise        = deb_q & ~deb_prev_q;
   assign active_held = step_up_q ? deb_q[0] : deb_q[1];
   assign other_held  = step_up_q ? deb_q[1] : deb_q[0];

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      step_en_d    = 1'b0;
      step_up_d    = step_up_q;
      load_d       = rise[2];
      load_value_d = rise[2] ? lv_s2_q : load_value_q;
      case (state_q)
         ST_IDLE: begin
            if (rise[0] && !deb_q[1]) begin
               step_en_d = 1'b1;
               step_up_d = 1'b1;
               timer_d   = '0;
               state_d   = ST_HOLD;
            end else if (rise[1] && !deb_q[0]) begin
               step_en_d = 1'b1;
               step_up_d = 1'b0;
               timer_d   = '0;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!active_held || other_held) begin
               state_d = ST_IDLE;
            end else if (timer_q == HOLD_TC) begin
               step_en_d = 1'b1;
               timer_d   = '0;
               state_d   = ST_REPEAT;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         ST_REPEAT: begin
            if (!active_held || other_held) begin
               state_d = ST_IDLE;
            end else if (timer_q == REP_TC) begin
               step_en_d = 1'b1;
               timer_d   = '0;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // a load request wins over any step activity and cancels repeat
      if (rise[2]) begin
         step_en_d = 1'b0;
         timer_d   = '0;
         state_d   = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1_q     <= '0;
         btn_s2_q     <= '0;
         lv_s1_q      <= '0;
         lv_s2_q      <= '0;
         deb_q        <= '0;
         deb_prev_q   <= '0;
         db_cnt_q     <= '0;
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         step_en_q    <= 1'b0;
         step_up_q    <= 1'b0;
         load_q       <= 1'b0;
         load_value_q <= '0;
      end else begin
         btn_s1_q     <= {btn_load, btn_down, btn_up};
         btn_s2_q     <= btn_s1_q;
         lv_s1_q      <= load_val;
         lv_s2_q      <= lv_s1_q;
         deb_q        <= deb_d;
         deb_prev_q   <= deb_q;
         db_cnt_q     <= db_cnt_d;
         state_q      <= state_d;
         timer_q      <= timer_d;
         step_en_q    <= step_en_d;
         step_up_q    <= step_up_d;
         load_q       <= load_d;
         load_value_q <= load_value_d;
      end
   end

   assign step_en    = step_en_q;
   assign step_up    = step_up_q;
   assign load       = load_q;
   assign load_value = load_value_q;

endmodule

// File: tb/tb_step_input_cond.sv
// Directed bench for step_input_cond: debounce latency, glitch rejection,
// hold/repeat timing, load priority, dual-press lockout and mid-repeat reset.
module tb_step_input_cond;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
   logic [3:0] load_val = 4'h0;
   logic       step_en, step_up, load;
   logic [3:0] load_value;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int viol    = 0;
   int pulses[$];
   int loads[$];
   logic [3:0] load_vals[$];
   logic prev_step_en = 1'b0;
   int c1, r1, lt;

   step_input_cond #(.DB_CYCLES(8), .HOLD_CYCLES(64), .REPEAT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
      .btn_load(btn_load), .load_val(load_val), .step_en(step_en),
      .step_up(step_up), .load(load), .load_value(load_value)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (step_en) pulses.push_back(cyc);
      if (load) begin
         loads.push_back(cyc);
         load_vals.push_back(load_value);
      end
      if (step_en && (load || prev_step_en)) viol++;
      prev_step_en = step_en;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int pulse_at(input int i);
      return (i < pulses.size()) ? pulses[i] : -1;
   endfunction

   task automatic clear_log();
      pulses.delete();
      loads.delete();
      load_vals.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      wait_cycles(3);
      check("rst_step_en", step_en, 0);
      check("rst_step_up", step_up, 0);
      check("rst_load", load, 0);
      check("rst_load_value", load_value, 0);
      rst_n = 1'b1;
      wait_cycles(5);

      // single up press held 10 cycles: one pulse 10 edges after first sample
      clear_log();
      btn_up = 1'b1;
      c1 = cyc + 1;
      wait_cycles(10);
      btn_up = 1'b0;
      wait_cycles(40);
      check("up_cnt", pulses.size(), 1);
      check("up_time", pulse_at(0), c1 + 10);
      check("up_dir", step_up, 1);

      // 5-cycle glitch on down is rejected
      clear_log();
      btn_down = 1'b1;
      wait_cycles(5);
      btn_down = 1'b0;
      wait_cycles(30);
      check("glitch_cnt", pulses.size(), 0);
      check("glitch_dir", step_up, 1);

      // clean down press
      clear_log();
      btn_down = 1'b1;
      c1 = cyc + 1;
      wait_cycles(15);
      btn_down = 1'b0;
      wait_cycles(40);
      check("down_cnt", pulses.size(), 1);
      check("down_time", pulse_at(0), c1 + 10);
      check("down_dir", step_up, 0);

      // hold and auto-repeat: t0, t0+64, then every 16
      clear_log();
      btn_up = 1'b1;
      c1 = cyc + 1;
      wait_cycles(200);
      btn_up = 1'b0;
      wait_cycles(60);
      check("rep_cnt", pulses.size(), 10);
      for (int k = 0; k < 10; k++)
         check($sformatf("rep_t%0d", k), pulse_at(k),
               c1 + 10 + ((k == 0) ? 0 : 64 + 16 * (k - 1)));
      check("rep_dir", step_up, 1);

      // load during repeat
      clear_log();
      load_val = 4'hA;
      btn_up = 1'b1;
      c1 = cyc + 1;
      wait_cycles(98);
      btn_load = 1'b1;
      wait_cycles(150);
      btn_load = 1'b0;
      btn_up = 1'b0;
      wait_cycles(40);
      check("ld_cnt", loads.size(), 1);
      lt = (loads.size() > 0) ? loads[0] : -1;
      check("ld_time", lt, c1 + 108);
      check("ld_value", (load_vals.size() > 0) ? load_vals[0] : 4'h0, 4'hA);
      check("ld_step_cnt", pulses.size(), 4);
      check("ld_step_last", pulse_at(3), c1 + 106);
      check("ld_dir", step_up, 1);

      // both step buttons together: no pulses
      clear_log();
      btn_up = 1'b1;
      btn_down = 1'b1;
      wait_cycles(100);
      btn_up = 1'b0;
      btn_down = 1'b0;
      wait_cycles(30);
      check("both_cnt", pulses.size(), 0);

      // reset mid-repeat, button kept held
      btn_up = 1'b1;
      wait_cycles(100);
      rst_n = 1'b0;
      #1;
      clear_log();
      check("rr_step_en", step_en, 0);
      check("rr_step_up", step_up, 0);
      check("rr_load", load, 0);
      check("rr_load_value", load_value, 0);
      wait_cycles(3);
      rst_n = 1'b1;
      r1 = cyc + 1;
      wait_cycles(30);
      check("rr_cnt", pulses.size(), 1);
      check("rr_time", pulse_at(0), r1 + 10);
      check("rr_dir", step_up, 1);
      btn_up = 1'b0;
      wait_cycles(30);

      check("overlap_consec", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
